pc_fetch_sequencer: RTL
=======================

// Module: pc_fetch_sequencer
// PURPOSE
//  Multicycle sequencer that owns the architectural PC register and drives next-PC
//  selection for the LEGv8 datapath: fetch handshake with instruction memory, execute
//  strobe to the datapath, then PC update (PC+4 or branch target) at retire.
//  Sits between the instruction memory and control unit/ALU; tracks retired and
//  taken-branch counts and halts on request or misaligned PC.
// PARAMETERS
//  CNT_W   32   width of retired_cnt / taken_cnt (saturating)
//  PC_INC  4    sequential PC increment in bytes
// PORTS
//  CLK           in   1   single clock, all state rising-edge
//  resetl        in   1   asynchronous, active-low reset
//  startPC       in   64  PC loaded on first clock after reset release
//  imem_ack      in   1   instruction memory word valid for currentPC
//  exec_done     in   1   datapath finished; Branch/Uncondbranch/ALUZero/SignExtImm64 valid
//  Branch        in   1   conditional branch (CBZ) from control
//  Uncondbranch  in   1   unconditional branch (B) from control
//  ALUZero       in   1   ALU zero flag
//  SignExtImm64  in   64  sign-extended word offset (units of instructions)
//  halt_req      in   1   stop at next instruction boundary
//  currentPC     out  64  architectural PC
//  imem_req      out  1   fetch request for currentPC
//  exec_en       out  1   high while datapath may execute fetched instruction
//  halted        out  1   FSM in HALT
//  misalign_err  out  1   sticky: PC with [1:0]!=0 produced
//  retired_cnt   out  CNT_W instructions retired
//  taken_cnt     out  CNT_W branches taken
// BEHAVIOUR
//  Reset (resetl=0, async): state=LOAD, currentPC=0, all other outputs 0, counters 0.
//  FSM (Moore outputs except noted): LOAD -> FETCH -> EXEC -> FETCH ... ; any -> HALT.
//  - LOAD: one cycle; currentPC<=startPC. If startPC[1:0]!=0: misalign_err<=1, ->HALT;
//    elif halt_req ->HALT; else ->FETCH.
//  - FETCH: imem_req=1, held until imem_ack; ack accepted in same cycle -> EXEC.
//    imem_ack outside FETCH ignored. halt_req not honored in FETCH.
//  - EXEC: exec_en=1 until exec_done; on exec_done (retire):
//    take = Uncondbranch | (Branch & ALUZero);
//    currentPC <= take ? currentPC + (SignExtImm64<<2) : currentPC + PC_INC (mod 2^64,
//    shift discards top 2 bits); retired_cnt+=1; taken_cnt+=take; both saturate at all-ones.
//    Next: new PC[1:0]!=0 -> misalign_err<=1, HALT (PC still updated);
//    elif halt_req -> HALT; else FETCH.
//  - HALT: terminal; imem_req=exec_en=0, halted=1; only reset exits.
//  Min 2 cycles/instruction (ack and exec_done each in first cycle of their state).
//  Branch inputs sampled only in the exec_done cycle; ignored otherwise.
//  Reset mid-FETCH/EXEC: immediate return to LOAD values; in-flight instruction discarded.
// TESTING
//  1 startPC=0x100, ack/exec_done immediate, no branch x3 -> PC 0x104,0x108,0x10C; retired=3, 2 cyc/instr.
//  2 PC=0x100, Branch=1,ALUZero=1,Imm=-1 -> PC=0xFC, taken=1; Branch=1,ALUZero=0 -> PC=0x104, taken=0.
//  3 PC=0x100, Uncondbranch=1, Imm=0x10 -> PC=0x140; ALUZero ignored; taken_cnt increments.
//  4 imem_ack delayed 3 cycles, exec_done delayed 2 -> imem_req high 4 cycles, exec_en high 3, PC stable.
//  5 startPC=0x1 -> misalign_err=1, halted=1 after LOAD, imem_req never asserted.
//  6 halt_req during EXEC -> retire completes, PC updated, HALT; resetl pulse mid-EXEC -> PC=0, LOAD.

Source files
------------

// File: rtl/pc_fetch_sequencer.sv
// ---------------------------------------------------------------------------
// pc_fetch_sequencer
// Multicycle sequencer that owns the architectural PC of the LEGv8 datapath.
// Each instruction runs as: fetch handshake with instruction memory, an
// execute window for the datapath, then a PC update at retire (PC+PC_INC or
// the branch target). It counts retired instructions and taken branches
// (saturating) and stops in a terminal HALT state on request or when a
// misaligned PC is produced.
//
// Ports
//   CLK           in   single clock, rising edge
//   resetl        in   asynchronous active-low reset
//   startPC       in   PC loaded in the first cycle after reset release
//   imem_ack      in   instruction word valid for currentPC (FETCH only)
//   exec_done     in   datapath finished; branch inputs valid this cycle
//   Branch        in   conditional branch (CBZ)
//   Uncondbranch  in   unconditional branch (B)
//   ALUZero       in   ALU zero flag
//   SignExtImm64  in   sign-extended word offset (instruction units)
//   halt_req      in   stop at the next instruction boundary
//   currentPC     out  architectural PC
//   imem_req      out  fetch request for currentPC
//   exec_en       out  datapath may execute the fetched instruction
//   halted        out  sequencer is in HALT
//   misalign_err  out  sticky flag: a PC with [1:0] != 0 was produced
//   retired_cnt   out  retired instructions (saturating)
//   taken_cnt     out  taken branches (saturating)
// ---------------------------------------------------------------------------
module pc_fetch_sequencer #(
    parameter int          CNT_W  = 32,
    parameter int unsigned PC_INC = 4
) (
    input  logic             CLK,
    input  logic             resetl,
    input  logic [63:0]      startPC,
    input  logic             imem_ack,
    input  logic             exec_done,
    input  logic             Branch,
    input  logic             Uncondbranch,
    input  logic             ALUZero,
    input  logic [63:0]      SignExtImm64,
    input  logic             halt_req,
    output logic [63:0]      currentPC,
    output logic             imem_req,
    output logic             exec_en,
    output logic             halted,
    output logic             misalign_err,
    output logic [CNT_W-1:0] retired_cnt,
    output logic [CNT_W-1:0] taken_cnt
);

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [63:0]      PC_STEP = 64'(PC_INC);

    state_t           state_r;
    state_t           state_next_s;
    logic [63:0]      pc_r;
    logic [63:0]      pc_next_s;
    logic [63:0]      branch_off_s;
    logic [CNT_W-1:0] retired_r;
    logic [CNT_W-1:0] retired_next_s;
    logic [CNT_W-1:0] taken_r;
    logic [CNT_W-1:0] taken_next_s;
    logic             misalign_r;
    logic             misalign_next_s;
    logic             take_s;
    logic             imem_req_r;
    logic             exec_en_r;
    logic             halted_r;

    // Word offset to byte offset; the top two bits fall off (mod 2^64).
    assign branch_off_s = SignExtImm64 << 2'd2;

    // Next-state, next-PC, counter and error-flag computation.
    always_comb begin
        state_next_s    = state_r;
        pc_next_s       = pc_r;
        retired_next_s  = retired_r;
        taken_next_s    = taken_r;
        misalign_next_s = misalign_r;
        take_s          = 1'b0;
        case (state_r)
            ST_LOAD: begin
                pc_next_s = startPC;
                if (startPC[1:0] != 2'b00) begin
                    misalign_next_s = 1'b1;
                    state_next_s    = ST_HALT;
                end else if (halt_req) begin
                    state_next_s = ST_HALT;
                end else begin
                    state_next_s = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (imem_ack) begin
                    state_next_s = ST_EXEC;
                end else begin
                    state_next_s = ST_FETCH;
                end
            end
            ST_EXEC: begin
                if (exec_done) begin
                    // Branch inputs only matter in the retire cycle.
                    take_s = Uncondbranch | (Branch & ALUZero);
                    if (take_s) begin
                        pc_next_s = pc_r + branch_off_s;
                    end else begin
                        pc_next_s = pc_r + PC_STEP;
                    end
                    if (retired_r != CNT_MAX) begin
                        retired_next_s = retired_r + CNT_ONE;
                    end else begin
                        retired_next_s = retired_r;
                    end
                    if (take_s && (taken_r != CNT_MAX)) begin
                        taken_next_s = taken_r + CNT_ONE;
                    end else begin
                        taken_next_s = taken_r;
                    end
                    // The PC is still updated when it turns out misaligned.
                    if (pc_next_s[1:0] != 2'b00) begin
                        misalign_next_s = 1'b1;
                        state_next_s    = ST_HALT;
                    end else if (halt_req) begin
                        state_next_s = ST_HALT;
                    end else begin
                        state_next_s = ST_FETCH;
                    end
                end else begin
                    state_next_s = ST_EXEC;
                end
            end
            ST_HALT: begin
                state_next_s = ST_HALT;
            end
            default: begin
                state_next_s = ST_HALT;
            end
        endcase
    end

    // State, PC, counters and registered Moore outputs (decoded from next state
    // so they line up with the state they describe).
    always_ff @(posedge CLK or negedge resetl) begin
        if (!resetl) begin
            state_r    <= ST_LOAD;
            pc_r       <= 64'd0;
            retired_r  <= '0;
            taken_r    <= '0;
            misalign_r <= 1'b0;
            imem_req_r <= 1'b0;
            exec_en_r  <= 1'b0;
            halted_r   <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            pc_r       <= pc_next_s;
            retired_r  <= retired_next_s;
            taken_r    <= taken_next_s;
            misalign_r <= misalign_next_s;
            imem_req_r <= (state_next_s == ST_FETCH);
            exec_en_r  <= (state_next_s == ST_EXEC);
            halted_r   <= (state_next_s == ST_HALT);
        end
    end

    assign currentPC    = pc_r;
    assign imem_req     = imem_req_r;
    assign exec_en      = exec_en_r;
    assign halted       = halted_r;
    assign misalign_err = misalign_r;
    assign retired_cnt  = retired_r;
    assign taken_cnt    = taken_r;

endmodule
